sr_latch_exerciser: RTL and testbench

//  Synthesizable driver/checker for an SR (cross-coupled NOR) latch: drives s/r

---
 rtl/sr_latch_exerciser_if.sv | 27 ++
 rtl/sr_latch_exerciser.sv | 150 +++++++++++++++
 tb/tb_sr_latch_exerciser.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sr_latch_exerciser_if.sv
// Bus between the SR-latch exerciser and its surroundings: run control and
// status toward the host, and s/r/q/qbar toward the latch under test.
interface sr_latch_exerciser_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             q;
  logic             qbar;
  logic             s;
  logic             r;
  logic             busy;
  logic             done;
  logic [3:0]       step_idx;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output start, q, qbar,
    input  s, r, busy, done, step_idx, pass_cnt, err_cnt, skip_cnt
  );

  modport slave (
    input  start, q, qbar,
    output s, r, busy, done, step_idx, pass_cnt, err_cnt, skip_cnt
  );
endinterface

// File: rtl/sr_latch_exerciser.sv
// SR latch self-test engine: walks an 11-step s/r pattern REPEAT times,
// samples the latch outputs through a 2-flop synchronizer and tallies
// pass/error/skip results against the expected latch behaviour.
module sr_latch_exerciser #(
  parameter int HOLD_CYCLES = 10,
  parameter int REPEAT      = 20,
  parameter int CNT_W       = 8
) (
  input  logic                clock,
  input  logic                resetn,
  sr_latch_exerciser_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = $clog2(REPEAT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(REPEAT - 1);

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [PW-1:0]    pass_num;
  logic [3:0]       step_idx;
  logic             s_q, r_q, busy_q, done_q;
  logic [CNT_W-1:0] pass_cnt, err_cnt, skip_cnt;
  logic             exp_q, exp_qb, exp_vld, prev_11;
  logic [1:0]       q_sync, qb_sync;
  logic             hold_last, last_step, last_pass, match;
  logic [3:0]       nxt_idx;
  logic [1:0]       nxt_sr;

  // Step pattern as {s,r}
  function automatic logic [1:0] pat(input logic [3:0] i);
    case (i)
      4'd0:    pat = 2'b01;
      4'd1:    pat = 2'b10;
      4'd3:    pat = 2'b11;
      4'd9:    pat = 2'b01;
      4'd10:   pat = 2'b10;
      default: pat = 2'b00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hold_last = (hold_cnt == HOLD_LAST);
  assign last_step = (step_idx == 4'd10);
  assign last_pass = (pass_num == PASS_LAST);
  assign match     = (q_sync[1] == exp_q) && (qb_sync[1] == exp_qb);

  // Next step index and drive; INIT and the end of step 10 both lead to step 0
  always_comb begin
    nxt_idx = '0;
    if (state == STEP && !last_step) nxt_idx = step_idx + 4'd1;
    nxt_sr = pat(nxt_idx);
  end

  // Two-flop synchronizer for the asynchronous latch outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_sync  <= '0;
      qb_sync <= '0;
    end else begin
      q_sync  <= {q_sync[0], bus.q};
      qb_sync <= {qb_sync[0], bus.qbar};
    end
  end

  // Run sequencer: step timing, drive pattern, expectation model and tallies
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pass_num <= '0;
      step_idx <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      skip_cnt <= '0;
      exp_q    <= 1'b0;
      exp_qb   <= 1'b0;
      exp_vld  <= 1'b0;
      prev_11  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state    <= INIT;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          pass_cnt <= '0;
          err_cnt  <= '0;
          skip_cnt <= '0;
          hold_cnt <= '0;
          pass_num <= '0;
          step_idx <= '0;
          s_q      <= 1'b0;
          r_q      <= 1'b0;
          exp_vld  <= 1'b0;
          prev_11  <= 1'b0;
        end
        INIT, STEP: begin
          hold_cnt <= hold_last ? '0 : hold_cnt + 1'b1;
          if (hold_last) begin
            // Last cycle of a step: exactly one tally moves
            if (state == STEP) begin
              if (!exp_vld)   skip_cnt <= sat_inc(skip_cnt);
              else if (match) pass_cnt <= sat_inc(pass_cnt);
              else            err_cnt  <= sat_inc(err_cnt);
            end
            if (state == STEP && last_step && last_pass) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              step_idx <= '0;
              s_q      <= 1'b0;
              r_q      <= 1'b0;
            end else begin
              state      <= STEP;
              step_idx   <= nxt_idx;
              {s_q, r_q} <= nxt_sr;
              if (state == STEP && last_step) pass_num <= pass_num + 1'b1;
              // 00 keeps the old expectation only if it came from 01/10
              case (nxt_sr)
                2'b01:   {exp_q, exp_qb, exp_vld} <= 3'b011;
                2'b10:   {exp_q, exp_qb, exp_vld} <= 3'b101;
                2'b11:   {exp_q, exp_qb, exp_vld} <= 3'b001;
                default: exp_vld <= exp_vld & ~prev_11;
              endcase
              prev_11 <= &nxt_sr;
            end
          end
        end
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step_idx;
  assign bus.pass_cnt = pass_cnt;
  assign bus.err_cnt  = err_cnt;
  assign bus.skip_cnt = skip_cnt;
endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Bench for sr_latch_exerciser: behavioural NOR latch with optional output
// corruption, per-cycle s/r/step trace check and end-of-run tally check.
module tb_sr_latch_exerciser;
  localparam int H   = 5;
  localparam int R   = 6;
  localparam int CW  = 5;
  localparam int N   = (1 + 11 * R) * H;
  localparam int SAT = (1 << CW) - 1;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  int          total  = 0;
  int          bad    = 0;
  int          mode   = 0;   // 0 ideal, 1 q/qbar tied low, 2 masked corruption
  logic [10:0] mask   = '0;
  logic        lq     = 1'b0;
  logic        lqb    = 1'b1;
  logic        corrupt;
  logic [1:0]  pat_tb [11] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

  sr_latch_exerciser_if #(.CNT_W(CW)) bus ();

  sr_latch_exerciser #(.HOLD_CYCLES(H), .REPEAT(R), .CNT_W(CW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Ideal cross-coupled NOR latch; 00 holds
  always @(bus.s or bus.r) begin
    case ({bus.s, bus.r})
      2'b10:   begin lq = 1'b1; lqb = 1'b0; end
      2'b01:   begin lq = 1'b0; lqb = 1'b1; end
      2'b11:   begin lq = 1'b0; lqb = 1'b0; end
      default: ;
    endcase
  end

  assign corrupt  = (mode == 2) && mask[bus.step_idx];
  assign bus.q    = (mode == 1) ? 1'b0 : (lq  ^ corrupt);
  assign bus.qbar = (mode == 1) ? 1'b0 : (lqb ^ corrupt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected tallies for a full run, derived step by step from the test rules
  function automatic void predict(input int md, input logic [10:0] mk,
                                  output int ep, output int ee, output int es);
    logic eq = 1'b0, eqb = 1'b0, ev = 1'b0, p11 = 1'b0;
    logic oq = 1'b0, oqb = 1'b1, c, gq, gqb;
    logic [1:0] sr;
    ep = 0; ee = 0; es = 0;
    for (int p = 0; p < R; p++) begin
      for (int i = 0; i < 11; i++) begin
        sr = pat_tb[i];
        if (sr == 2'b01)      begin eq = 1'b0; eqb = 1'b1; ev = 1'b1; end
        else if (sr == 2'b10) begin eq = 1'b1; eqb = 1'b0; ev = 1'b1; end
        else if (sr == 2'b11) begin eq = 1'b0; eqb = 1'b0; ev = 1'b1; end
        else if (p11)         ev = 1'b0;
        p11 = (sr == 2'b11);
        if (sr != 2'b00) begin oq = sr[1] & ~sr[0]; oqb = sr[0] & ~sr[1]; end
        c   = (md == 2) && mk[i];
        gq  = (md == 1) ? 1'b0 : (oq  ^ c);
        gqb = (md == 1) ? 1'b0 : (oqb ^ c);
        if (!ev)                        es++;
        else if ({gq, gqb} == {eq, eqb}) ep++;
        else                            ee++;
      end
    end
    if (ep > SAT) ep = SAT;
    if (ee > SAT) ee = SAT;
    if (es > SAT) es = SAT;
  endfunction

  task automatic run(input int md, input logic [10:0] mk, input bit glitch);
    int         ep, ee, es, ph, j;
    logic [7:0] want;
    mode = md;
    mask = mk;
    predict(md, mk, ep, ee, es);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    chk("clr_pass", bus.pass_cnt, 0);
    chk("clr_err",  bus.err_cnt,  0);
    chk("clr_skip", bus.skip_cnt, 0);
    for (int t = 0; t < N; t++) begin
      ph   = t / H;
      j    = (ph == 0) ? 0 : (ph - 1) % 11;
      want = {((ph == 0) ? 2'b00 : pat_tb[j]), 4'(j), 2'b10};
      chk("trace", {bus.s, bus.r, bus.step_idx, bus.busy, bus.done}, want);
      bus.start = glitch && (t < N - 1) && ($urandom_range(0, 30) == 0);
      @(negedge clock);
    end
    bus.start = 1'b0;
    chk("done_edge", {bus.s, bus.r, bus.step_idx, bus.busy, bus.done}, 8'b0000_0001);
    chk("pass_cnt", bus.pass_cnt, ep);
    chk("err_cnt",  bus.err_cnt,  ee);
    chk("skip_cnt", bus.skip_cnt, es);
    @(negedge clock);
    chk("done_held", {bus.busy, bus.done}, 2'b01);
    chk("frozen",    {bus.pass_cnt, bus.err_cnt, bus.skip_cnt}, {5'(ep), 5'(ee), 5'(es)});
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_sr",    {bus.s, bus.r}, 2'b00);
    chk("rst_stat",  {bus.busy, bus.done, bus.step_idx}, 6'd0);
    chk("rst_cnts",  {bus.pass_cnt, bus.err_cnt, bus.skip_cnt}, 15'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle",      {bus.s, bus.r, bus.busy, bus.done, bus.step_idx}, 8'd0);

    run(0, '0, 1'b0);                // ideal latch, pass count saturates
    run(1, '0, 1'b0);                // outputs tied low
    run(2, 11'($urandom), 1'b1);     // random corruption + ignored starts
    run(2, 11'($urandom), 1'b1);
    run(2, 11'h7ff, 1'b0);           // every step corrupted

    // Abort during step 5 of pass 4
    mode = 0;
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    repeat (H * (1 + 33 + 5) + $urandom_range(0, H - 1)) @(negedge clock);
    chk("pre_abort", {bus.busy, bus.step_idx}, 5'b1_0101);
    resetn = 1'b0;
    #1;
    chk("abort_out",  {bus.s, bus.r, bus.busy, bus.done, bus.step_idx}, 8'd0);
    chk("abort_cnts", {bus.pass_cnt, bus.err_cnt, bus.skip_cnt}, 15'd0);
    @(negedge clock); resetn = 1'b1;
    run(0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
